serial_out_stage: RTL

- Downstream of the user module; consumes the 8-bit parallel words it produces.
- Buffers the words in a small FIFO and transmits them on one wire as UART-style frames: start, LSB-first data, optional parity, stop.
- Gives the bench and silicon a single-pin readout of io_out activity.
- Single clock domain, no CDC.

---
 rtl/serial_out_pkg.sv | 48 ++++
 rtl/serial_out_stage_sync_fifo.sv | 79 +++++++
 rtl/serial_out_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_out_pkg.sv
// -----------------------------------------------------------------------------
// serial_out_pkg
// Shared types and constants for the serial readout stage.
//   - tx_state_e  : transmitter FSM state encoding
//   - IDLE_LEVEL  : level driven on the serial line when no frame is active
//   - TIMER_W     : bit-timer width, wide enough for CLKS_PER_BIT up to 255
//   - *_DEF       : default parameter values used by serial_out_stage
//   - level_width / index_width : widths derived from the module parameters
// Optional feature macro: SERIAL_OUT_PARITY_EN (adds the even_parity helper).
// -----------------------------------------------------------------------------
package serial_out_pkg;

  localparam logic IDLE_LEVEL       = 1'b1;

  localparam int   DATA_W_DEF       = 8;
  localparam int   CLKS_PER_BIT_DEF = 4;
  localparam int   FIFO_DEPTH_DEF   = 4;

  // CLKS_PER_BIT is limited to 1..255, so the reload value always fits 8 bits.
  localparam int   TIMER_W          = 8;
  localparam int   LEVEL_W_DEF      = $clog2(FIFO_DEPTH_DEF) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Bit index counts 0..data_w-1.
  function automatic int index_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

`ifdef SERIAL_OUT_PARITY_EN
  // Even parity: XOR of all data bits (zero-extended upper bits do not change it).
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction
`endif

endpackage

// File: rtl/serial_out_stage_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rstn        : clock, async active-low reset (pointers/count cleared)
//   push, wr_data    : write request and data (ignored when full)
//   pop              : read request (ignored when empty); rd_data shows head
//   full, empty      : status decoded from the registered occupancy count
//   level            : registered occupancy, 0..FIFO_DEPTH
// FIFO_DEPTH must be a power of two (pointers wrap naturally), at least 2.
// -----------------------------------------------------------------------------
module sync_fifo
  import serial_out_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  count_r;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic              full_s;
  logic              empty_s;

  assign full_s    = (count_r == LVL_W'(FIFO_DEPTH));
  assign empty_s   = (count_r == {LVL_W{1'b0}});
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty_s;

  assign full    = full_s;
  assign empty   = empty_s;
  assign level   = count_r;
  assign rd_data = mem_r[rd_ptr_r];

  // Storage array; contents need no reset because count_r gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + LVL_W'(1);
        2'b01:   count_r <= count_r - LVL_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/serial_out_stage.sv
// -----------------------------------------------------------------------------
// serial_out_stage
// Buffers parallel words in a small FIFO and shifts them out on one wire as
// UART-style frames: start (0), DATA_W bits LSB first, optional even parity,
// stop (1). Back-to-back words are sent with no idle gap between frames.
// Ports:
//   clk        : system clock, rising edge
//   rstn       : async active-low reset, released synchronously inside
//   in_data    : word to enqueue
//   in_valid   : in_data valid; accepted when in_ready is high
//   in_ready   : FIFO not full
//   tx         : registered serial line, idles high
//   busy       : registered, high while a frame is in progress
//   fifo_level : FIFO occupancy
// Optional feature macro: SERIAL_OUT_PARITY_EN inserts a PARITY bit after DATA.
// -----------------------------------------------------------------------------
module serial_out_stage
  import serial_out_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int                 IDX_W      = index_width(DATA_W);
  localparam logic [TIMER_W-1:0] BIT_RELOAD = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DATA_W - 1);

  // Reset: asserts with rstn, deasserts two clk edges after rstn rises.
  logic [1:0]         rst_sync_r;
  logic               rst_n_s;

  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [DATA_W-1:0]  rd_data_s;

  tx_state_e          state_r;
  tx_state_e          state_nxt_s;
  logic [TIMER_W-1:0] timer_r;
  logic [TIMER_W-1:0] timer_nxt_s;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   idx_nxt_s;
  logic [DATA_W-1:0]  shift_r;
  logic [DATA_W-1:0]  shift_nxt_s;
  logic               tx_r;
  logic               tx_nxt_s;
  logic               busy_r;
  logic               busy_nxt_s;
  logic               timer_done_s;
`ifdef SERIAL_OUT_PARITY_EN
  logic               parity_r;
  logic               parity_nxt_s;
`endif

  // Reset synchronizer for the release edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  assign push_s   = in_valid && !full_s;
  assign in_ready = !full_s;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rst_n_s),
    .push    (push_s),
    .wr_data (in_data),
    .pop     (pop_s),
    .rd_data (rd_data_s),
    .full    (full_s),
    .empty   (empty_s),
    .level   (fifo_level)
  );

  assign timer_done_s = (timer_r == {TIMER_W{1'b0}});

  // Next-state, next-output and FIFO pop decode for the transmitter.
  // tx_nxt_s is the line level for the state being entered, so tx stays registered.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    tx_nxt_s    = tx_r;
    pop_s       = 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
    parity_nxt_s = parity_r;
`endif
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          shift_nxt_s = rd_data_s;
          timer_nxt_s = BIT_RELOAD;
          idx_nxt_s   = {IDX_W{1'b0}};
          state_nxt_s = START;
          tx_nxt_s    = 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
          parity_nxt_s = even_parity(64'(rd_data_s));
`endif
        end else begin
          state_nxt_s = IDLE;
          tx_nxt_s    = IDLE_LEVEL;
        end
      end
      START: begin
        if (timer_done_s) begin
          timer_nxt_s = BIT_RELOAD;
          idx_nxt_s   = {IDX_W{1'b0}};
          state_nxt_s = DATA;
          tx_nxt_s    = shift_r[0];
        end else begin
          timer_nxt_s = timer_r - TIMER_W'(1);
          tx_nxt_s    = 1'b0;
        end
      end
      DATA: begin
        if (timer_done_s) begin
          timer_nxt_s = BIT_RELOAD;
          shift_nxt_s = shift_r >> 1'b1;
          if (idx_r == LAST_IDX) begin
            idx_nxt_s = {IDX_W{1'b0}};
`ifdef SERIAL_OUT_PARITY_EN
            state_nxt_s = PARITY;
            tx_nxt_s    = parity_r;
`else
            state_nxt_s = STOP;
            tx_nxt_s    = IDLE_LEVEL;
`endif
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
            // Next bit is the one that lands in bit 0 after this shift.
            tx_nxt_s  = shift_r[1];
          end
        end else begin
          timer_nxt_s = timer_r - TIMER_W'(1);
          tx_nxt_s    = shift_r[0];
        end
      end
`ifdef SERIAL_OUT_PARITY_EN
      PARITY: begin
        if (timer_done_s) begin
          timer_nxt_s = BIT_RELOAD;
          state_nxt_s = STOP;
          tx_nxt_s    = IDLE_LEVEL;
        end else begin
          timer_nxt_s = timer_r - TIMER_W'(1);
          tx_nxt_s    = parity_r;
        end
      end
`endif
      STOP: begin
        if (timer_done_s) begin
          if (!empty_s) begin
            // Chain straight into the next frame with no idle gap.
            pop_s       = 1'b1;
            shift_nxt_s = rd_data_s;
            timer_nxt_s = BIT_RELOAD;
            idx_nxt_s   = {IDX_W{1'b0}};
            state_nxt_s = START;
            tx_nxt_s    = 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
            parity_nxt_s = even_parity(64'(rd_data_s));
`endif
          end else begin
            state_nxt_s = IDLE;
            tx_nxt_s    = IDLE_LEVEL;
          end
        end else begin
          timer_nxt_s = timer_r - TIMER_W'(1);
          tx_nxt_s    = IDLE_LEVEL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        timer_nxt_s = {TIMER_W{1'b0}};
        idx_nxt_s   = {IDX_W{1'b0}};
        shift_nxt_s = {DATA_W{1'b0}};
        tx_nxt_s    = IDLE_LEVEL;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // Transmitter state, shift register and registered line outputs.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= IDLE;
      timer_r <= {TIMER_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      shift_r <= {DATA_W{1'b0}};
      tx_r    <= IDLE_LEVEL;
      busy_r  <= 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      timer_r <= timer_nxt_s;
      idx_r   <= idx_nxt_s;
      shift_r <= shift_nxt_s;
      tx_r    <= tx_nxt_s;
      busy_r  <= busy_nxt_s;
`ifdef SERIAL_OUT_PARITY_EN
      parity_r <= parity_nxt_s;
`endif
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;

endmodule
